// File: rtl/ctl_missile_pool.sv
// Enemy missile controller: N_SLOTS independent missiles launched from the enemy
// position into the lowest free slot, falling one STEP per shared movement tick.
module ctl_missile_pool #(
  parameter int N_SLOTS   = 4,
  parameter int SPEED_DIV = 90000,
  parameter int STEP      = 1,
  parameter int Y_MAX     = 768,
  parameter int COOLDOWN  = 16
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic [10:0]            xpos_in,
  input  logic [10:0]            ypos_in,
  input  logic                   fire,
  input  logic                   enemy_lives,
  input  logic [N_SLOTS-1:0]     hit_clr,
  output logic [11*N_SLOTS-1:0]  xpos_out,
  output logic [11*N_SLOTS-1:0]  ypos_out,
  output logic [N_SLOTS-1:0]     on_out,
  output logic                   fire_ack,
  output logic                   full
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FLY  = 1'b1
  } slot_state_e;

  localparam int CNT_W = $clog2(SPEED_DIV);
  localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          tick;
  logic [CD_W-1:0]               cd_q, cd_d;
  slot_state_e                   state_q [N_SLOTS];
  slot_state_e                   state_d [N_SLOTS];
  logic [N_SLOTS-1:0][10:0]      x_q, x_d;
  logic [N_SLOTS-1:0][10:0]      y_q, y_d;
  logic [N_SLOTS-1:0][11:0]      y_step;
  logic                          fire_ack_q, fire_ack_d;
  logic                          full_q, full_d;
  logic [N_SLOTS-1:0]            idle_vec;
  logic [N_SLOTS-1:0]            launch_oh;
  logic [N_SLOTS-1:0]            fly_d_vec;
  logic                          launch_ok;
  logic                          pick_done;

  // Shared movement tick: free-running divider restarted by reset.
  always_comb begin
    tick  = (cnt_q == CNT_W'(SPEED_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Launch goes to the lowest-index slot that is IDLE as of this cycle, so a slot
  // retiring or cleared now only becomes available on the following cycle.
  always_comb begin
    launch_oh = '0;
    pick_done = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      idle_vec[k] = (state_q[k] == S_IDLE);
    end
    launch_ok = fire && enemy_lives && (cd_q == '0) && (|idle_vec);
    for (int k = 0; k < N_SLOTS; k++) begin
      if (launch_ok && idle_vec[k] && !pick_done) begin
        launch_oh[k] = 1'b1;
        pick_done    = 1'b1;
      end
    end
  end

  always_comb begin
    cd_d = cd_q;
    if (launch_ok) begin
      cd_d = CD_W'(COOLDOWN);
    end else if (tick && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      // NOTE: every next-state variable is given its hold value first, so no path
      // through the case below can leave it unassigned and infer a latch.
      state_d[k] = state_q[k];
      x_d[k]     = x_q[k];
      y_d[k]     = y_q[k];
      y_step[k]  = {1'b0, y_q[k]} + 12'(STEP);

      case (state_q[k])
        S_IDLE: begin
          if (launch_oh[k]) begin
            state_d[k] = S_FLY;
            x_d[k]     = xpos_in;
            y_d[k]     = ypos_in;
          end
        end
        S_FLY: begin
          if (hit_clr[k]) begin
            state_d[k] = S_IDLE;
          end else if (tick) begin
            if (y_step[k] >= 12'(Y_MAX)) begin
              state_d[k] = S_IDLE;
            end else begin
              y_d[k] = y_step[k][10:0];
            end
          end
        end
        default: state_d[k] = S_IDLE;
      endcase

      fly_d_vec[k] = (state_d[k] == S_FLY);
    end
  end

  always_comb begin
    fire_ack_d = launch_ok;
    full_d     = &fly_d_vec;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt_q      <= '0;
      cd_q       <= '0;
      fire_ack_q <= 1'b0;
      full_q     <= 1'b0;
      // NOTE: the position registers are cleared as well, because the outputs they
      // drive must read zero after reset rather than keep stale coordinates.
      x_q        <= '0;
      y_q        <= '0;
      for (int k = 0; k < N_SLOTS; k++) begin
        state_q[k] <= S_IDLE;
      end
    end else begin
      // NOTE: state registers take non-blocking assignments only; the blocking
      // assignments belong to the always_comb next-state logic above.
      cnt_q      <= cnt_d;
      cd_q       <= cd_d;
      fire_ack_q <= fire_ack_d;
      full_q     <= full_d;
      x_q        <= x_d;
      y_q        <= y_d;
      for (int k = 0; k < N_SLOTS; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      on_out[k] = (state_q[k] == S_FLY);
    end
    xpos_out = x_q;
    ypos_out = y_q;
    fire_ack = fire_ack_q;
    full     = full_q;
  end

endmodule

// File: tb/tb_ctl_missile_pool.sv
// Self-checking bench for ctl_missile_pool: directed scenarios plus random traffic,
// every cycle compared against a slot-list reference model.
module tb_ctl_missile_pool;

  localparam int N_SLOTS   = 4;
  localparam int SPEED_DIV = 4;
  localparam int STEP      = 1;
  localparam int Y_MAX     = 20;
  localparam int COOLDOWN  = 2;

  logic                  pclk;
  logic                  rst;
  logic [10:0]           xpos_in;
  logic [10:0]           ypos_in;
  logic                  fire;
  logic                  enemy_lives;
  logic [N_SLOTS-1:0]    hit_clr;
  logic [11*N_SLOTS-1:0] xpos_out;
  logic [11*N_SLOTS-1:0] ypos_out;
  logic [N_SLOTS-1:0]    on_out;
  logic                  fire_ack;
  logic                  full;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: a list of missiles with plain integer coordinates.
  bit m_on [N_SLOTS];
  int m_x  [N_SLOTS];
  int m_y  [N_SLOTS];
  int m_cd;
  int m_cyc;
  bit m_ack;
  bit m_full;

  ctl_missile_pool #(
    .N_SLOTS  (N_SLOTS),
    .SPEED_DIV(SPEED_DIV),
    .STEP     (STEP),
    .Y_MAX    (Y_MAX),
    .COOLDOWN (COOLDOWN)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .xpos_in    (xpos_in),
    .ypos_in    (ypos_in),
    .fire       (fire),
    .enemy_lives(enemy_lives),
    .hit_clr    (hit_clr),
    .xpos_out   (xpos_out),
    .ypos_out   (ypos_out),
    .on_out     (on_out),
    .fire_ack   (fire_ack),
    .full       (full)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int slot;
    bit tick;
    if (rst) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        m_on[k] = 1'b0;
        m_x[k]  = 0;
        m_y[k]  = 0;
      end
      m_cd   = 0;
      m_cyc  = 0;
      m_ack  = 1'b0;
      m_full = 1'b0;
      return;
    end
    tick = ((m_cyc % SPEED_DIV) == SPEED_DIV - 1);
    slot = -1;
    if (fire && enemy_lives && m_cd == 0) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        if (!m_on[k] && slot < 0) slot = k;
      end
    end
    for (int k = 0; k < N_SLOTS; k++) begin
      if (k == slot) begin
        m_on[k] = 1'b1;
        m_x[k]  = int'(xpos_in);
        m_y[k]  = int'(ypos_in);
      end else if (m_on[k]) begin
        if (hit_clr[k]) begin
          m_on[k] = 1'b0;
        end else if (tick) begin
          if (m_y[k] + STEP >= Y_MAX) m_on[k] = 1'b0;
          else m_y[k] = m_y[k] + STEP;
        end
      end
    end
    if (slot >= 0) m_cd = COOLDOWN;
    else if (tick && m_cd > 0) m_cd = m_cd - 1;
    m_ack  = (slot >= 0);
    m_full = 1'b1;
    for (int k = 0; k < N_SLOTS; k++) m_full = m_full & m_on[k];
    m_cyc++;
  endtask

  task automatic compare_all();
    logic [N_SLOTS-1:0] exp_on;
    for (int k = 0; k < N_SLOTS; k++) exp_on[k] = m_on[k];
    check("on_out", on_out, exp_on);
    check("fire_ack", fire_ack, m_ack);
    check("full", full, m_full);
    for (int k = 0; k < N_SLOTS; k++) begin
      check($sformatf("xpos%0d", k), xpos_out[11*k +: 11], 64'(m_x[k]));
      check($sformatf("ypos%0d", k), ypos_out[11*k +: 11], 64'(m_y[k]));
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int         acks;
    int         max_y;
    bit         gone;
    bit         got;
    logic [10:0] y_before;

    rst = 1'b1; fire = 1'b0; enemy_lives = 1'b1; hit_clr = '0;
    xpos_in = '0; ypos_in = '0;
    #1;

    // 1: reset then quiet
    repeat (3) step();
    rst = 1'b0;
    repeat (100) step();
    check("t1_on", on_out, 4'b0000);

    // 2: single launch, fall to retirement
    xpos_in = 11'd100; ypos_in = 11'd10; fire = 1'b1;
    step();
    fire = 1'b0;
    check("t2_on", on_out, 4'b0001);
    check("t2_x", xpos_out[10:0], 11'd100);
    check("t2_y", ypos_out[10:0], 11'd10);
    check("t2_ack", fire_ack, 1'b1);
    max_y = 0; gone = 1'b0;
    for (int i = 0; i < 60 && !gone; i++) begin
      step();
      if (on_out[0]) max_y = int'(ypos_out[10:0]);
      else gone = 1'b1;
    end
    check("t2_ymax", 64'(max_y), 64'd19);
    check("t2_retire", gone, 1'b1);

    // 3: held fire fills all slots, then refused
    xpos_in = 11'd200; ypos_in = 11'd0; fire = 1'b1; acks = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      acks += int'(fire_ack);
    end
    fire = 1'b0;
    check("t3_acks", 64'(acks), 64'd4);
    check("t3_full", full, 1'b1);

    // 4: clear slot 1, next launch reuses it
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0; fire = 1'b1; ypos_in = 11'd0; acks = 0;
    for (int i = 0; i < 60 && acks < 3; i++) begin
      step();
      acks += int'(fire_ack);
    end
    fire = 1'b0;
    check("t4_three", 64'(acks), 64'd3);
    check("t4_on", on_out, 4'b0111);
    hit_clr = 4'b0010;
    step();
    hit_clr = '0;
    check("t4_clr", on_out, 4'b0101);
    xpos_in = 11'd300; fire = 1'b1; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = fire_ack;
    end
    fire = 1'b0;
    check("t4_ack", got, 1'b1);
    check("t4_reland", on_out, 4'b0111);
    check("t4_x1", xpos_out[21:11], 11'd300);

    // 5: dead enemy cannot fire; missiles still fall
    enemy_lives = 1'b0; fire = 1'b1; acks = 0;
    y_before = ypos_out[10:0];
    repeat (16) begin
      step();
      acks += int'(fire_ack);
    end
    fire = 1'b0; enemy_lives = 1'b1;
    check("t5_noack", 64'(acks), 64'd0);
    check("t5_move", 64'(ypos_out[10:0] - y_before), 64'd4);

    // 6: reset mid-flight, then relaunch into slot 0
    rst = 1'b1;
    step();
    check("t6_on", on_out, 4'b0000);
    check("t6_pos", ypos_out, '0);
    rst = 1'b0; fire = 1'b1; xpos_in = 11'd5; ypos_in = 11'd3;
    step();
    fire = 1'b0;
    check("t6_slot0", on_out, 4'b0001);
    check("t6_ack", fire_ack, 1'b1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      fire        = ($urandom_range(0, 2) == 0);
      enemy_lives = ($urandom_range(0, 9) != 0);
      hit_clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      xpos_in     = 11'($urandom);
      ypos_in     = 11'($urandom_range(0, 22));
      rst         = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
